// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: bus widths and MEM-stage access FSM encodings.
package mips_pkg;
  localparam int MIPS_DATA_W = 32;
  localparam int MIPS_ADDR_W = 32;

  typedef enum logic [1:0] {
    MAC_IDLE = 2'd0,
    MAC_BUSY = 2'd1,
    MAC_DONE = 2'd2
  } mac_state_e;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-RAM req/ack bus between the MEM-stage controller (master) and the RAM (slave).
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_access_ctrl_timeout_ctr.sv
// Clearable, enabled up-counter with a terminal-count flag, shared by pipeline stall sources.
module mac_timeout_ctr #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
)(
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [TO_W-1:0] cnt_q, cnt_d;

  // tc fires on the TIMEOUT-th enabled edge after a clear
  assign tc_o = en_i & (cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + TO_W'(1);
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: req/ack to a variable-latency RAM, ReadData and pipe stall.
module mem_access_ctrl
  import mips_pkg::*;
#(
  parameter int DATA_W  = MIPS_DATA_W,
  parameter int ADDR_W  = MIPS_ADDR_W,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  mem_access_ctrl_if.master mem,
  output logic [DATA_W-1:0] ReadData,
  output logic              pipe_enable,
  output logic              bus_error
);
  mac_state_e        state_q, state_d;
  logic              req_q, req_d, we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              access, to_tc, ctr_clr, ctr_en;

  assign access  = MemRead | MemWrite;
  assign ctr_clr = (state_q == MAC_IDLE);
  assign ctr_en  = (state_q == MAC_BUSY);

  mac_timeout_ctr #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_to (
    .clk   (clk),
    .reset (reset),
    .clr_i (ctr_clr),
    .en_i  (ctr_en),
    .tc_o  (to_tc)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    pipe_enable = 1'b0;
    case (state_q)
      MAC_IDLE: begin
        // stall in the same cycle the access is presented
        pipe_enable = ~access;
        if (access) begin
          addr_d  = Address;
          wdata_d = WriteData;
          we_d    = MemWrite;
          req_d   = 1'b1;
          state_d = MAC_BUSY;
        end
      end
      MAC_BUSY: begin
        // ack beats a coincident timeout
        if (mem.mem_ack) begin
          req_d   = 1'b0;
          if (!we_q) rdata_d = mem.mem_rdata;
          state_d = MAC_DONE;
        end else if (to_tc) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          if (!we_q) rdata_d = '0;
          state_d = MAC_DONE;
        end
      end
      MAC_DONE: begin
        pipe_enable = 1'b1;
        state_d     = MAC_IDLE;
      end
      default: state_d = MAC_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MAC_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign ReadData      = rdata_q;
  assign bus_error     = err_q;
endmodule
